mul_add2_result_history: RTL and testbench

MUL_ADD2_RESULT_HISTORY -- requirements
Module: mul_add2_result_history

---
 rtl/mul_add2_pkg.sv | 18 +
 rtl/mul_add2_history_ram.sv | 27 ++
 rtl/mul_add2_result_history.sv | 113 +++++++++++
 tb/tb_mul_add2_result_history.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_add2_pkg.sv
// Shared defaults and constant helpers for the mul_add2 result-history block.
package mul_add2_pkg;

  localparam int NEQ_DEFAULT   = 9;
  localparam int EW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 4;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_add2_history_ram.sv
// History storage: one write port and one registered read port, read-before-write.
module mul_add2_history_ram
  import mul_add2_pkg::*;
#(
  parameter int width      = NEQ_DEFAULT * EW_DEFAULT,
  parameter int depth      = DEPTH_DEFAULT,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [width-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [width-1:0]      rd_data
);

  logic [width-1:0] mem [depth];

  // NOTE: storage and its read register carry no reset; the top never exposes
  // them until a valid entry has been written and a hit has been read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mul_add2_result_history.sv
// Ring buffer of the last D result vectors with per-element masked merge,
// age-addressed registered reads and a combinational newest-entry view.
module mul_add2_result_history
  import mul_add2_pkg::*;
#(
  parameter int number_of_equations_per_cluster = NEQ_DEFAULT,
  parameter int element_width                   = EW_DEFAULT,
  parameter int history_depth                   = DEPTH_DEFAULT,
  localparam int AW = (clog2(history_depth) < 1) ? 1 : clog2(history_depth),
  localparam int CW = clog2(history_depth + 1)
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    clear,
  input  logic                                                    write_enable,
  input  logic [number_of_equations_per_cluster-1:0]              element_mask,
  input  logic [element_width*number_of_equations_per_cluster-1:0] input_data,
  input  logic                                                    read_enable,
  input  logic [AW-1:0]                                           read_age,
  output logic [element_width*number_of_equations_per_cluster-1:0] memory_output,
  output logic                                                    output_valid,
  output logic [element_width*number_of_equations_per_cluster-1:0] newest_output,
  output logic [CW-1:0]                                           entry_count,
  output logic                                                    full
);

  localparam int NEQ = number_of_equations_per_cluster;
  localparam int EW  = element_width;
  localparam int D   = history_depth;
  localparam int DW  = NEQ * EW;
  localparam int PW  = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] newest_q;
  logic [DW-1:0] merged;
  logic [DW-1:0] ram_rd_data;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_idx;
  logic          hit;
  logic          zero_q;
  logic          valid_q;
  logic          ram_wr_en;
  logic          ram_rd_en;

  assign entry_count   = count;
  assign full          = (count == CW'(D));
  assign newest_output = (count == '0) ? '0 : newest_q;
  assign hit           = 32'(read_age) < 32'(count);
  assign ram_wr_en     = write_enable && !clear && !rst;
  assign ram_rd_en     = read_enable && hit && !clear && !rst;
  assign memory_output = zero_q ? '0 : ram_rd_data;
  assign output_valid  = valid_q;

  // Masked-off elements inherit the newest entry, which already reads as zero when empty.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NEQ; i++) begin
      merged[EW*i +: EW] = element_mask[i] ? input_data[EW*i +: EW]
                                           : newest_output[EW*i +: EW];
    end
  end

  // Age 0 sits one slot behind the write pointer; the index only matters on a hit.
  always_comb begin
    rd_idx = PW'(wr_ptr) + PW'(D - 1) - PW'(read_age);
    if (rd_idx >= PW'(D)) rd_idx = rd_idx - PW'(D);
    rd_addr = rd_idx[AW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which gives read-before-write for free.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      if (write_enable) begin
        wr_ptr <= (wr_ptr == AW'(D - 1)) ? '0 : wr_ptr + AW'(1);
        if (count != CW'(D)) count <= count + CW'(1);
      end
      if (read_enable) begin
        valid_q <= hit;
        zero_q  <= !hit;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  // Shadow of the age-0 entry so the merge and newest view need no RAM read port.
  always_ff @(posedge clk) begin
    if (ram_wr_en) newest_q <= merged;
  end

  mul_add2_history_ram #(
    .width      (DW),
    .depth      (D),
    .addr_width (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr),
    .wr_data (merged),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_mul_add2_result_history.sv
// Scoreboarded random + directed bench for mul_add2_result_history against a queue-based model.
module tb_mul_add2_result_history;

  localparam int NEQ = 9;
  localparam int EW  = 32;
  localparam int D   = 4;
  localparam int AW  = 2;
  localparam int CW  = 3;
  localparam int DW  = NEQ * EW;

  typedef logic [DW-1:0] entry_t;
  typedef struct {
    logic   valid;
    entry_t data;
  } resp_t;

  logic           clk;
  logic           rst;
  logic           clear;
  logic           write_enable;
  logic [NEQ-1:0] element_mask;
  entry_t         input_data;
  logic           read_enable;
  logic [AW-1:0]  read_age;
  entry_t         memory_output;
  logic           output_valid;
  entry_t         newest_output;
  logic [CW-1:0]  entry_count;
  logic           full;

  mul_add2_result_history #(
    .number_of_equations_per_cluster (NEQ),
    .element_width                   (EW),
    .history_depth                   (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .write_enable  (write_enable),
    .element_mask  (element_mask),
    .input_data    (input_data),
    .read_enable   (read_enable),
    .read_age      (read_age),
    .memory_output (memory_output),
    .output_valid  (output_valid),
    .newest_output (newest_output),
    .entry_count   (entry_count),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t model_q[$];   // index 0 = newest
  entry_t last_out;
  resp_t  exp_q[$];
  int     n_checks;
  int     n_fail;
  bit     resp_due;
  bit     model_known;

  task automatic check(input string name, input entry_t act, input entry_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic entry_t model_newest();
    return (model_q.size() == 0) ? entry_t'(0) : model_q[0];
  endfunction

  function automatic entry_t fill(input logic [EW-1:0] v);
    entry_t e;
    for (int i = 0; i < NEQ; i++) e[EW*i +: EW] = v;
    return e;
  endfunction

  function automatic entry_t ramp();
    entry_t e;
    for (int i = 0; i < NEQ; i++) e[EW*i +: EW] = EW'(i + 1);
    return e;
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    for (int i = 0; i < NEQ; i++) e[EW*i +: EW] = $urandom;
    return e;
  endfunction

  // One cycle: check visible state, drive inputs, advance the model, queue the expected response.
  task automatic step(input bit r, input bit c, input bit w, input logic [NEQ-1:0] m,
                      input entry_t d, input bit re, input logic [AW-1:0] age);
    resp_t  exp;
    entry_t nw;
    entry_t mg;
    @(negedge clk);
    if (model_known) begin
      check("entry_count", entry_t'(entry_count), entry_t'(model_q.size()));
      check("full", entry_t'(full), entry_t'(model_q.size() == D));
      check("newest_output", newest_output, model_newest());
    end
    rst          = r;
    clear        = c;
    write_enable = w;
    element_mask = m;
    input_data   = d;
    read_enable  = re;
    read_age     = age;
    exp.valid    = 1'b0;
    if (r || c) begin
      model_q.delete();
      last_out    = '0;
      model_known = 1'b1;
    end else begin
      if (re) begin
        if (int'(age) < model_q.size()) begin
          exp.valid = 1'b1;
          last_out  = model_q[age];
        end else begin
          last_out = '0;
        end
      end
      if (w) begin
        nw = model_newest();
        for (int i = 0; i < NEQ; i++)
          mg[EW*i +: EW] = m[i] ? d[EW*i +: EW] : nw[EW*i +: EW];
        model_q.push_front(mg);
        if (model_q.size() > D) void'(model_q.pop_back());
      end
    end
    exp.data = last_out;
    exp_q.push_back(exp);
    resp_due = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic wr(input logic [NEQ-1:0] m, input entry_t d);
    step(0, 0, 1, m, d, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] age);
    step(0, 0, 0, '0, '0, 1, age);
  endtask

  // Monitor: one response is due after every edge that followed a driven cycle.
  initial begin : monitor
    bit    due;
    resp_t e;
    forever begin
      @(posedge clk);
      due = resp_due;
      #1;
      if (due) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got no expected entry, required one");
        end else begin
          e = exp_q.pop_front();
          check("output_valid", entry_t'(output_valid), entry_t'(e.valid));
          check("memory_output", memory_output, e.data);
        end
      end
    end
  end

  initial begin : driver
    entry_t a, b;
    rst = 1'b1; clear = 1'b0; write_enable = 1'b0; element_mask = '0;
    input_data = '0; read_enable = 1'b0; read_age = '0;
    n_checks = 0; n_fail = 0; resp_due = 1'b0; model_known = 1'b0;
    last_out = '0;

    step(1, 0, 0, '0, '0, 0, '0);
    step(1, 0, 0, '0, '0, 1, '0);

    // Mask merge
    wr('1, ramp());
    wr(9'h001, fill(32'hAA));
    rd(0);
    rd(1);
    idle();

    // Wrap and saturation
    step(0, 1, 0, '0, '0, 0, '0);
    for (int k = 1; k <= 6; k++) wr('1, fill(EW'(k)));
    for (int g = 0; g < 4; g++) rd(AW'(g));
    wr(9'h0F0, fill(32'h7));
    rd(3);

    // Miss versus hit
    step(0, 1, 0, '0, '0, 0, '0);
    wr('1, rand_entry());
    wr('1, rand_entry());
    rd(3);
    idle();
    rd(1);
    rd(2);

    // Read together with write
    a = rand_entry();
    b = rand_entry();
    step(0, 1, 0, '0, '0, 0, '0);
    wr('1, a);
    wr('1, b);
    step(0, 0, 1, '1, rand_entry(), 1, 2'd0);
    rd(0);

    // Clear priority, then a mask-0 write into an empty buffer
    step(0, 1, 1, '1, rand_entry(), 1, 2'd0);
    wr('0, rand_entry());
    rd(0);

    // Reset while full, with a write pending
    for (int k = 0; k < 4; k++) wr('1, rand_entry());
    rd(3);
    step(1, 0, 1, '1, rand_entry(), 1, 2'd0);
    rd(0);
    wr(9'h100, rand_entry());
    rd(0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(63) == 0), ($urandom_range(31) == 0), $urandom_range(1) == 1,
           NEQ'($urandom), rand_entry(), $urandom_range(1) == 1, AW'($urandom));
    end

    idle();
    @(negedge clk);
    resp_due = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", entry_t'(exp_q.size()), entry_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
